// File: rtl/multi_shift_accum_ram_pkg.sv
// rtl/multi_shift_accum_ram_pkg.sv - shared op encoding and clear-sweep state constants
package accum_pkg;

  typedef enum logic [1:0] {
    ACC_READ  = 2'd0,
    ACC_SHIFT = 2'd1,
    ACC_LOAD  = 2'd2
  } accum_op_t;

  typedef logic [1:0] clr_state_t;

  localparam clr_state_t CLR_IDLE  = 2'd0;
  localparam clr_state_t CLR_DRAIN = 2'd1;
  localparam clr_state_t CLR_SWEEP = 2'd2;

  // Cycles spent letting S1/S2 empty before the sweep owns port B.
  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/multi_shift_accum_ram_if.sv
// rtl/multi_shift_accum_ram_if.sv - request/result bundle between decode front end and accumulator store
interface multi_shift_accum_ram_if
  import accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int SHIFT = 1
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              req_valid_in;
  logic              req_ready_out;
  logic [ADDR_W-1:0] req_addr_in;
  accum_op_t         req_op_in;
  logic [SHIFT-1:0]  req_data_in;
  logic              clear_all_in;
  logic              busy_out;
  logic              result_valid_out;
  logic [ADDR_W-1:0] addr_out;
  accum_op_t         op_out;
  logic [WIDTH-1:0]  read_out;
  logic [WIDTH-1:0]  sum_out;

  modport master (
    output req_valid_in, req_addr_in, req_op_in, req_data_in, clear_all_in,
    input  req_ready_out, busy_out, result_valid_out, addr_out, op_out, read_out, sum_out
  );

  modport slave (
    input  req_valid_in, req_addr_in, req_op_in, req_data_in, clear_all_in,
    output req_ready_out, busy_out, result_valid_out, addr_out, op_out, read_out, sum_out
  );

endinterface

// File: rtl/multi_shift_accum_ram_clear_sweeper.sv
// rtl/multi_shift_accum_ram_clear_sweeper.sv - clear FSM: drain, zero sweep over port B, request gating
module accum_clear_sweeper
  import accum_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              clear_all_in,
  input  logic              s2_we_in,
  input  logic [ADDR_W-1:0] s2_addr_in,
  input  logic [WIDTH-1:0]  s2_data_in,
  output logic              req_ready_out,
  output logic              busy_out,
  output logic              sweep_done_out,
  output logic              ram_we_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [WIDTH-1:0]  ram_data_out
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        state_q, state_d;
  logic              drain_cnt_q, drain_cnt_d;
  logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    sweep_addr_d   = sweep_addr_q;
    sweep_done_out = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clear_all_in) begin
          state_d     = CLR_DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      CLR_DRAIN: begin
        if (drain_cnt_q == 1'(DRAIN_CYCLES - 1)) begin
          state_d      = CLR_SWEEP;
          sweep_addr_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      CLR_SWEEP: begin
        if (sweep_addr_q == LAST_ADDR) begin
          state_d        = CLR_IDLE;
          sweep_done_out = 1'b1;
        end else begin
          sweep_addr_d = sweep_addr_q + 1'b1;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= CLR_IDLE;
      drain_cnt_q  <= 1'b0;
      sweep_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      sweep_addr_q <= sweep_addr_d;
    end
  end

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign req_ready_out = rst_n_in && (state_q == CLR_IDLE) && !clear_all_in;
  assign busy_out      = (state_q != CLR_IDLE);

  // S2 cannot be valid during SWEEP because the drain emptied it first.
  assign ram_we_out   = (state_q == CLR_SWEEP) ? 1'b1         : s2_we_in;
  assign ram_addr_out = (state_q == CLR_SWEEP) ? sweep_addr_q : s2_addr_in;
  assign ram_data_out = (state_q == CLR_SWEEP) ? '0           : s2_data_in;

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv - single-clock true dual port RAM, read-first, optional output register
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int RAM_WIDTH       = 16,
  parameter int RAM_DEPTH       = 256,
  parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic                         clka,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic [RAM_WIDTH-1:0]         dinb,
  input  logic                         wea,
  input  logic                         web,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         rsta,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data_a;

  // Port A reads the pre-write value when both ports hit the same word.
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_data_a <= mem[addra];
    end
    if (enb && web) mem[addrb] <= dinb;
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
      assign douta = ram_data_a;
    end else begin : g_high_performance
      logic [RAM_WIDTH-1:0] douta_q;
      always_ff @(posedge clka) begin
        if (rsta)        douta_q <= '0;
        else if (regcea) douta_q <= ram_data_a;
      end
      assign douta = douta_q;
    end
  endgenerate

endmodule

// File: rtl/multi_shift_accum_ram.sv
// rtl/multi_shift_accum_ram.sv - shift-accumulate word store, 2-cycle read-modify-write with forwarding
module multi_shift_accum_ram
  import accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int SHIFT = 1
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  multi_shift_accum_ram_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              accept, ready_w, busy_w, w_clear;
  logic              s1_valid_q, s2_valid_q;
  logic [ADDR_W-1:0] s1_addr_q, s2_addr_q;
  accum_op_t         s1_op_q, s2_op_q;
  logic [SHIFT-1:0]  s1_data_q, s2_data_q;

  logic              w1_valid_q, w2_valid_q;
  logic [ADDR_W-1:0] w1_addr_q, w2_addr_q;
  logic [WIDTH-1:0]  w1_data_q, w2_data_q;

  logic [WIDTH-1:0]       ram_rd, old_val, sum_val, ram_wdata;
  logic [WIDTH+SHIFT-1:0] shifted;
  logic                   s2_we, ram_we;
  logic [ADDR_W-1:0]      ram_waddr;

  assign accept            = bus.req_valid_in && ready_w;
  assign bus.req_ready_out = ready_w;
  assign bus.busy_out      = busy_w;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_op_q    <= ACC_READ;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_op_q    <= ACC_READ;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= bus.req_addr_in;
        s1_op_q   <= bus.req_op_in;
        s1_data_q <= bus.req_data_in;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_q <= s1_addr_q;
        s2_op_q   <= s1_op_q;
        s2_data_q <= s1_data_q;
      end
    end
  end

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH      (WIDTH),
    .RAM_DEPTH      (DEPTH),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE")
  ) u_ram (
    .clka  (clk_in),
    .addra (bus.req_addr_in),
    .addrb (ram_waddr),
    .dina  ('0),
    .dinb  (ram_wdata),
    .wea   (1'b0),
    .web   (ram_we),
    .ena   (1'b1),
    .enb   (1'b1),
    .rsta  (1'b0),
    .regcea(1'b1),
    .douta (ram_rd)
  );

  // W1 is checked last so the newest write to a word takes priority.
  always_comb begin
    old_val = ram_rd;
    if (w2_valid_q && (w2_addr_q == s2_addr_q)) old_val = w2_data_q;
    if (w1_valid_q && (w1_addr_q == s2_addr_q)) old_val = w1_data_q;
    shifted = {old_val, s2_data_q};
    case (s2_op_q)
      ACC_SHIFT: sum_val = shifted[WIDTH-1:0];
      ACC_LOAD:  sum_val = WIDTH'(s2_data_q);
      default:   sum_val = old_val;
    endcase
  end

  assign s2_we = s2_valid_q && ((s2_op_q == ACC_SHIFT) || (s2_op_q == ACC_LOAD));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      w1_valid_q <= 1'b0;
      w1_addr_q  <= '0;
      w1_data_q  <= '0;
      w2_valid_q <= 1'b0;
      w2_addr_q  <= '0;
      w2_data_q  <= '0;
    end else if (w_clear) begin
      w1_valid_q <= 1'b0;
      w2_valid_q <= 1'b0;
    end else if (s2_we) begin
      w2_valid_q <= w1_valid_q;
      w2_addr_q  <= w1_addr_q;
      w2_data_q  <= w1_data_q;
      w1_valid_q <= 1'b1;
      w1_addr_q  <= s2_addr_q;
      w1_data_q  <= sum_val;
    end
  end

  accum_clear_sweeper #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_sweeper (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .clear_all_in  (bus.clear_all_in),
    .s2_we_in      (s2_we),
    .s2_addr_in    (s2_addr_q),
    .s2_data_in    (sum_val),
    .req_ready_out (ready_w),
    .busy_out      (busy_w),
    .sweep_done_out(w_clear),
    .ram_we_out    (ram_we),
    .ram_addr_out  (ram_waddr),
    .ram_data_out  (ram_wdata)
  );

  // Gated so the result bus reads 0 whenever no result is presented.
  assign bus.result_valid_out = s2_valid_q;
  assign bus.addr_out         = s2_valid_q ? s2_addr_q : '0;
  assign bus.op_out           = s2_valid_q ? s2_op_q   : ACC_READ;
  assign bus.read_out         = s2_valid_q ? old_val   : '0;
  assign bus.sum_out          = s2_valid_q ? sum_val   : '0;

endmodule

// File: tb/tb_multi_shift_accum_ram.sv
// tb/tb_multi_shift_accum_ram.sv - randomized and directed bench against a sequential memory model
module tb_multi_shift_accum_ram;
  import accum_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int SHIFT  = 2;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_shift_accum_ram_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SHIFT(SHIFT)) bus_if ();

  multi_shift_accum_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus_if)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    accum_op_t         op;
    logic [WIDTH-1:0]  rd;
    logic [WIDTH-1:0]  sum;
    int                t;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int clr_left = 0;
  exp_t exp_q[$];
  logic [WIDTH-1:0] obs_sum[$];
  logic [WIDTH-1:0] obs_rd[$];
  logic [WIDTH-1:0] model_mem [DEPTH];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_apply(accum_op_t op, logic [WIDTH-1:0] old, logic [SHIFT-1:0] d);
    int v;
    case (op)
      ACC_SHIFT: v = (int'(old) * (2 ** SHIFT) + int'(d)) % (2 ** WIDTH);
      ACC_LOAD:  v = int'(d);
      default:   v = int'(old);
    endcase
    return WIDTH'(v);
  endfunction

  exp_t e;
  bit exp_busy, exp_ready;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_busy  = (clr_left > 0);
      exp_ready = !exp_busy && !bus_if.clear_all_in;
      check("busy", bus_if.busy_out, exp_busy);
      check("ready", bus_if.req_ready_out, exp_ready);
      if (bus_if.result_valid_out) begin
        obs_sum.push_back(bus_if.sum_out);
        obs_rd.push_back(bus_if.read_out);
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_addr", bus_if.addr_out, e.addr);
          check("res_op", bus_if.op_out, e.op);
          check("res_read", bus_if.read_out, e.rd);
          check("res_sum", bus_if.sum_out, e.sum);
          check("res_latency", cyc - e.t, 2);
        end
      end
      if (bus_if.req_valid_in && exp_ready) begin
        e.addr = bus_if.req_addr_in;
        e.op   = bus_if.req_op_in;
        e.rd   = model_mem[e.addr];
        e.sum  = model_apply(e.op, e.rd, bus_if.req_data_in);
        e.t    = cyc;
        exp_q.push_back(e);
        model_mem[e.addr] = e.sum;
      end
      if (exp_busy) clr_left--;
      if (bus_if.clear_all_in && !exp_busy) begin
        clr_left = 2 + DEPTH;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end
    end
  end

  task automatic drive(input bit v, input int a, input accum_op_t op, input int d, input bit clr);
    bus_if.req_valid_in = v;
    bus_if.req_addr_in  = a[ADDR_W-1:0];
    bus_if.req_op_in    = op;
    bus_if.req_data_in  = d[SHIFT-1:0];
    bus_if.clear_all_in = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, ACC_READ, 0, 0);
    repeat (n) tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus_if.busy_out && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic do_clear();
    drive(0, 0, ACC_READ, 0, 1);
    tick();
    drive(0, 0, ACC_READ, 0, 0);
    wait_idle();
    tick();
  endtask

  task automatic obs_reset();
    obs_sum.delete();
    obs_rd.delete();
  endtask

  logic [WIDTH-1:0] t1_exp [5] = '{8'h03, 8'h0F, 8'h3F, 8'hFF, 8'hFD};
  logic [WIDTH-1:0] t2_exp [3] = '{8'h01, 8'h01, 8'h05};
  logic [WIDTH-1:0] t3_rd  [3] = '{8'h00, 8'h02, 8'h02};
  int busy_cnt;
  int nz;

  initial begin
    drive(0, 0, ACC_READ, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus_if.req_ready_out, 0);
    check("rst_busy", bus_if.busy_out, 0);
    check("rst_result_valid", bus_if.result_valid_out, 0);
    check("rst_sum", bus_if.sum_out, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", bus_if.req_ready_out, 1);
    tick();
    do_clear();

    // Repeated shift-in to one word, back to back, then MSB truncation.
    obs_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, ACC_SHIFT, 3, 0);
      tick();
    end
    drive(1, 3, ACC_SHIFT, 1, 0);
    tick();
    idle(4);
    check("t1_count", obs_sum.size(), 5);
    for (int i = 0; i < 5 && i < obs_sum.size(); i++) check("t1_sum", obs_sum[i], t1_exp[i]);

    // Interleaved addresses exercise W2 forwarding.
    obs_reset();
    drive(1, 5, ACC_SHIFT, 1, 0); tick();
    drive(1, 6, ACC_SHIFT, 1, 0); tick();
    drive(1, 5, ACC_SHIFT, 1, 0); tick();
    idle(4);
    check("t2_count", obs_sum.size(), 3);
    for (int i = 0; i < 3 && i < obs_sum.size(); i++) check("t2_sum", obs_sum[i], t2_exp[i]);

    // Load then read through forwarding, then read from RAM.
    obs_reset();
    drive(1, 2, ACC_LOAD, 2, 0); tick();
    drive(1, 2, ACC_READ, 0, 0); tick();
    idle(3);
    drive(1, 2, ACC_READ, 0, 0); tick();
    idle(4);
    check("t3_count", obs_rd.size(), 3);
    for (int i = 0; i < 3 && i < obs_rd.size(); i++) check("t3_read", obs_rd[i], t3_rd[i]);
    if (obs_sum.size() > 1) check("t3_read_sum", obs_sum[1], 2);

    // Fill every word, clear, count busy span, then read back zeros.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, a, ACC_LOAD, 1 + $urandom_range(2), 0);
      tick();
    end
    idle(3);
    drive(0, 0, ACC_READ, 0, 1);
    #1;
    check("ready_on_clear_pulse", bus_if.req_ready_out, 0);
    tick();
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus_if.busy_out) break;
      busy_cnt++;
      drive(1, $urandom_range(DEPTH - 1), ACC_LOAD, 3, 0);
      tick();
    end
    drive(0, 0, ACC_READ, 0, 0);
    check("busy_span", busy_cnt, 2 + DEPTH);
    obs_reset();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, a, ACC_READ, 0, 0);
      tick();
    end
    idle(4);
    nz = 0;
    foreach (obs_rd[i]) if (obs_rd[i] != 0) nz++;
    check("t4_count", obs_rd.size(), DEPTH);
    check("t4_nonzero_after_clear", nz, 0);

    // Clear wins over a coincident request; retry after busy is accepted.
    drive(1, 7, ACC_LOAD, 3, 1);
    #1;
    check("t5_ready_coincident", bus_if.req_ready_out, 0);
    tick();
    drive(0, 0, ACC_READ, 0, 0);
    wait_idle();
    obs_reset();
    drive(1, 7, ACC_LOAD, 3, 0);
    #1;
    check("t5_ready_retry", bus_if.req_ready_out, 1);
    tick();
    idle(3);
    check("t5_count", obs_sum.size(), 1);
    if (obs_sum.size() > 0) check("t5_sum", obs_sum[0], 3);

    // Reset mid-sweep.
    drive(0, 0, ACC_READ, 0, 1);
    tick();
    idle(8);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    clr_left = 0;
    #1;
    check("rst_sweep_busy", bus_if.busy_out, 0);
    check("rst_sweep_ready", bus_if.req_ready_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_sweep_ready_release", bus_if.req_ready_out, 1);
    check("rst_sweep_busy_release", bus_if.busy_out, 0);
    tick();

    // Reset mid-pipeline: in-flight results vanish.
    drive(1, 1, ACC_LOAD, 2, 0); tick();
    drive(1, 1, ACC_SHIFT, 1, 0); tick();
    drive(0, 0, ACC_READ, 0, 0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    clr_left = 0;
    #1;
    check("rst_pipe_valid", bus_if.result_valid_out, 0);
    check("rst_pipe_sum", bus_if.sum_out, 0);
    check("rst_pipe_read", bus_if.read_out, 0);
    check("rst_pipe_addr", bus_if.addr_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_pipe_ready_release", bus_if.req_ready_out, 1);
    obs_reset();
    idle(5);
    check("no_result_after_reset", obs_sum.size(), 0);
    do_clear();

    // Random traffic concentrated on a few words to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0,
            ($urandom % 2) ? int'($urandom % 4) : int'($urandom % DEPTH),
            accum_op_t'($urandom % 3),
            int'($urandom % (2 ** SHIFT)),
            ($urandom % 150) == 0);
      tick();
    end
    idle(4);
    wait_idle();
    idle(4);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
